// File: rtl/time_counter.sv
// 24-hour real-time clock: divides clk to a 1 Hz enable and keeps hour/minute/second.
// Optional preset load port group is enabled with `define TIME_COUNTER_PRESET_EN.
module time_counter #(
  parameter int unsigned TICK_DIV = 100000000,
  parameter int unsigned CNT_W    = 27
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       inc_min,
  input  logic       inc_hr,
`ifdef TIME_COUNTER_PRESET_EN
  input  logic       load,
  input  logic [6:0] load_hour,
  input  logic [6:0] load_min,
`endif
  output logic [6:0] second,
  output logic [6:0] minute,
  output logic [6:0] hour,
  output logic       tick
);

  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] pre_cnt;
  logic [CNT_W-1:0] pre_nxt;
  logic             sec_en;
  logic             manual;
  logic [6:0]       sec_nxt;
  logic [6:0]       min_nxt;
  logic [6:0]       hr_nxt;
  logic             tick_nxt;
  logic             sec_wrap;
  logic             min_wrap;
  logic [6:0]       sec_inc;
  logic [6:0]       min_inc;
  logic [6:0]       hr_inc;

  assign sec_en = run & (pre_cnt == PRE_LAST);
  assign manual = inc_min | inc_hr;

  assign sec_wrap = (second == 7'd59);
  assign min_wrap = (minute == 7'd59);
  assign sec_inc  = sec_wrap ? 7'd0 : second + 7'd1;
  assign min_inc  = min_wrap ? 7'd0 : minute + 7'd1;
  assign hr_inc   = (hour == 7'd23) ? 7'd0 : hour + 7'd1;

`ifdef TIME_COUNTER_PRESET_EN
  // An out-of-range preset is dropped entirely; the cycle proceeds as if load were low.
  logic load_ok;
  assign load_ok = load & (load_hour <= 7'd23) & (load_min <= 7'd59);
`endif

  always_comb begin
    pre_nxt  = pre_cnt;
    sec_nxt  = second;
    min_nxt  = minute;
    hr_nxt   = hour;
    tick_nxt = 1'b0;

    if (run) begin
      pre_nxt = sec_en ? '0 : pre_cnt + 1'b1;
    end

`ifdef TIME_COUNTER_PRESET_EN
    if (load_ok) begin
      pre_nxt = '0;
      hr_nxt  = load_hour;
      min_nxt = load_min;
      sec_nxt = 7'd0;
    end else
`endif
    if (manual) begin
      // Manual set swallows a coincident second tick; the prescaler still wraps.
      if (inc_min) begin
        min_nxt = min_inc;
        sec_nxt = 7'd0;
        pre_nxt = '0;
      end
      if (inc_hr) begin
        hr_nxt = hr_inc;
      end
    end else if (sec_en) begin
      tick_nxt = 1'b1;
      sec_nxt  = sec_inc;
      if (sec_wrap) begin
        min_nxt = min_inc;
        if (min_wrap) begin
          hr_nxt = hr_inc;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_cnt <= '0;
      second  <= 7'd0;
      minute  <= 7'd0;
      hour    <= 7'd0;
      tick    <= 1'b0;
    end else begin
      pre_cnt <= pre_nxt;
      second  <= sec_nxt;
      minute  <= min_nxt;
      hour    <= hr_nxt;
      tick    <= tick_nxt;
    end
  end

endmodule

// File: tb/tb_time_counter.sv
// Self-checking bench for time_counter; reference keeps time as seconds-of-day.
module tb_time_counter;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       run = 1'b0;
  logic       inc_min = 1'b0;
  logic       inc_hr = 1'b0;
`ifdef TIME_COUNTER_PRESET_EN
  logic       load = 1'b0;
  logic [6:0] load_hour = 7'd0;
  logic [6:0] load_min = 7'd0;
`endif
  logic [6:0] second;
  logic [6:0] minute;
  logic [6:0] hour;
  logic       tick;

  int checks = 0;
  int errors = 0;

  int m_tod = 0;
  int m_phase = 0;
  bit m_tick = 1'b0;

  always #5 clk = ~clk;

  time_counter #(.TICK_DIV(DIV), .CNT_W(3)) dut (
    .clk(clk),
    .rst(rst),
    .run(run),
    .inc_min(inc_min),
    .inc_hr(inc_hr),
`ifdef TIME_COUNTER_PRESET_EN
    .load(load),
    .load_hour(load_hour),
    .load_min(load_min),
`endif
    .second(second),
    .minute(minute),
    .hour(hour),
    .tick(tick)
  );

  task automatic model_step();
    int h, mi, s, nph;
    bit sec_evt;
    if (!rst) begin
      m_tod = 0; m_phase = 0; m_tick = 1'b0;
      return;
    end
    sec_evt = run && (m_phase == DIV - 1);
    nph = run ? (m_phase + 1) % DIV : m_phase;
    m_tick = 1'b0;
`ifdef TIME_COUNTER_PRESET_EN
    if (load && load_hour < 24 && load_min < 60) begin
      m_tod = int'(load_hour) * 3600 + int'(load_min) * 60;
      m_phase = 0;
      return;
    end
`endif
    if (inc_min || inc_hr) begin
      h = m_tod / 3600; mi = (m_tod / 60) % 60; s = m_tod % 60;
      if (inc_min) begin mi = (mi + 1) % 60; s = 0; nph = 0; end
      if (inc_hr) h = (h + 1) % 24;
      m_tod = h * 3600 + mi * 60 + s;
    end else if (sec_evt) begin
      m_tod = (m_tod + 1) % 86400;
      m_tick = 1'b1;
    end
    m_phase = nph;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    model_step();
  endtask

  task automatic do_reset();
    rst = 1'b0; run = 1'b0; inc_min = 1'b0; inc_hr = 1'b0;
`ifdef TIME_COUNTER_PRESET_EN
    load = 1'b0;
`endif
    cycle();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; run = 1'b1;
    cycle(); cycle();
    checks++; if (second !== 7'd0) begin errors++; $display("FAIL reset_second: got %0d expected 0", second); end
    checks++; if (minute !== 7'd0) begin errors++; $display("FAIL reset_minute: got %0d expected 0", minute); end
    checks++; if (hour !== 7'd0) begin errors++; $display("FAIL reset_hour: got %0d expected 0", hour); end
    checks++; if (tick !== 1'b0) begin errors++; $display("FAIL reset_tick: got %0b expected 0", tick); end
  endtask

  task automatic test_tick_latency();
    rst = 1'b1; run = 1'b1;
    for (int c = 1; c <= 240; c++) begin
      cycle();
      checks++;
      if (tick !== ((c % DIV) == 0)) begin
        errors++; $display("FAIL latency_tick cycle %0d: got %0b expected %0b", c, tick, (c % DIV) == 0);
      end
      if (c <= 12) begin
        checks++;
        if (second !== 7'(c / DIV)) begin
          errors++; $display("FAIL latency_second cycle %0d: got %0d expected %0d", c, second, c / DIV);
        end
      end
    end
    checks++; if (minute !== 7'd1) begin errors++; $display("FAIL minute_carry: got %0d expected 1", minute); end
    checks++; if (second !== 7'd0) begin errors++; $display("FAIL minute_carry_sec: got %0d expected 0", second); end
  endtask

  task automatic test_rollover();
    do_reset();
    inc_hr = 1'b1; repeat (23) cycle(); inc_hr = 1'b0;
    inc_min = 1'b1; repeat (59) cycle(); inc_min = 1'b0;
    checks++;
    if ({hour, minute, second} !== {7'd23, 7'd59, 7'd0}) begin
      errors++; $display("FAIL rollover_set: got %0d:%0d:%0d expected 23:59:0", hour, minute, second);
    end
    run = 1'b1;
    repeat (59 * DIV) cycle();
    checks++;
    if ({hour, minute, second} !== {7'd23, 7'd59, 7'd59}) begin
      errors++; $display("FAIL rollover_pre: got %0d:%0d:%0d expected 23:59:59", hour, minute, second);
    end
    repeat (DIV) cycle();
    checks++;
    if ({hour, minute, second, tick} !== {7'd0, 7'd0, 7'd0, 1'b1}) begin
      errors++; $display("FAIL rollover_wrap: got %0d:%0d:%0d tick %0b expected 0:0:0 tick 1", hour, minute, second, tick);
    end
  endtask

  task automatic test_pause();
    do_reset();
    run = 1'b1; repeat (2) cycle();
    run = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      checks++;
      if (second !== 7'd0 || tick !== 1'b0) begin
        errors++; $display("FAIL pause_hold: got sec %0d tick %0b expected sec 0 tick 0", second, tick);
      end
    end
    run = 1'b1;
    cycle();
    checks++; if (tick !== 1'b0) begin errors++; $display("FAIL pause_resume1: got tick %0b expected 0", tick); end
    cycle();
    checks++;
    if (tick !== 1'b1 || second !== 7'd1) begin
      errors++; $display("FAIL pause_resume2: got tick %0b sec %0d expected tick 1 sec 1", tick, second);
    end
  endtask

  task automatic test_collision();
    do_reset();
    inc_hr = 1'b1; repeat (5) cycle(); inc_hr = 1'b0;
    inc_min = 1'b1; repeat (59) cycle(); inc_min = 1'b0;
    run = 1'b1;
    repeat (30 * DIV) cycle();
    checks++;
    if ({hour, minute, second} !== {7'd5, 7'd59, 7'd30}) begin
      errors++; $display("FAIL collide_setup: got %0d:%0d:%0d expected 5:59:30", hour, minute, second);
    end
    repeat (DIV - 1) cycle();
    inc_min = 1'b1; cycle(); inc_min = 1'b0;
    checks++;
    if ({hour, minute, second, tick} !== {7'd5, 7'd0, 7'd0, 1'b0}) begin
      errors++; $display("FAIL collide_result: got %0d:%0d:%0d tick %0b expected 5:0:0 tick 0", hour, minute, second, tick);
    end
    repeat (DIV - 1) cycle();
    checks++; if (tick !== 1'b0) begin errors++; $display("FAIL collide_early_tick: got %0b expected 0", tick); end
    cycle();
    checks++;
    if (tick !== 1'b1 || second !== 7'd1) begin
      errors++; $display("FAIL collide_next_tick: got tick %0b sec %0d expected tick 1 sec 1", tick, second);
    end
  endtask

  task automatic test_async_reset();
    int seen;
    do_reset();
    run = 1'b1;
    repeat (6) cycle();
    #2;
    rst = 1'b0;
    #1;
    m_tod = 0; m_phase = 0; m_tick = 1'b0;
    checks++;
    if ({hour, minute, second, tick} !== 22'd0) begin
      errors++; $display("FAIL async_reset: got %0d:%0d:%0d tick %0b expected 0:0:0 tick 0", hour, minute, second, tick);
    end
    cycle();
    rst = 1'b1;
    seen = 0;
    for (int c = 1; c <= 3 * DIV && seen == 0; c++) begin
      cycle();
      if (tick === 1'b1) seen = c;
    end
    checks++;
    if (seen != DIV) begin
      errors++; $display("FAIL async_first_tick: got cycle %0d expected %0d (0 = timeout)", seen, DIV);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    inc_min = 1'b1; repeat (3) cycle(); inc_min = 1'b0;
    checks++; if (minute !== 7'd3) begin errors++; $display("FAIL held_inc_min: got %0d expected 3", minute); end
    inc_min = 1'b1; inc_hr = 1'b1; cycle(); inc_min = 1'b0; inc_hr = 1'b0;
    checks++;
    if ({hour, minute, second} !== {7'd1, 7'd4, 7'd0}) begin
      errors++; $display("FAIL both_inc: got %0d:%0d:%0d expected 1:4:0", hour, minute, second);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      run = ($urandom_range(0, 9) != 0);
      inc_min = ($urandom_range(0, 39) == 0);
      inc_hr = ($urandom_range(0, 39) == 0);
`ifdef TIME_COUNTER_PRESET_EN
      load = ($urandom_range(0, 99) == 0);
      load_hour = 7'($urandom_range(0, 31));
      load_min = 7'($urandom_range(0, 63));
`endif
      cycle();
      checks++;
      if ({hour, minute, second, tick} !== {7'(m_tod / 3600), 7'((m_tod / 60) % 60), 7'(m_tod % 60), m_tick}) begin
        errors++;
        $display("FAIL random iter %0d: got %0d:%0d:%0d tick %0b expected %0d:%0d:%0d tick %0b",
                 i, hour, minute, second, tick, m_tod / 3600, (m_tod / 60) % 60, m_tod % 60, m_tick);
      end
      checks++;
      if (hour > 7'd23 || minute > 7'd59 || second > 7'd59) begin
        errors++; $display("FAIL range iter %0d: got %0d:%0d:%0d expected within 23:59:59", i, hour, minute, second);
      end
    end
    run = 1'b0; inc_min = 1'b0; inc_hr = 1'b0;
`ifdef TIME_COUNTER_PRESET_EN
    load = 1'b0;
`endif
  endtask

`ifdef TIME_COUNTER_PRESET_EN
  task automatic test_preset();
    do_reset();
    load = 1'b1; load_hour = 7'd13; load_min = 7'd45; cycle(); load = 1'b0;
    checks++;
    if ({hour, minute, second} !== {7'd13, 7'd45, 7'd0}) begin
      errors++; $display("FAIL preset_load: got %0d:%0d:%0d expected 13:45:0", hour, minute, second);
    end
    load = 1'b1; load_hour = 7'd24; load_min = 7'd10; cycle(); load = 1'b0;
    checks++;
    if ({hour, minute, second} !== {7'd13, 7'd45, 7'd0}) begin
      errors++; $display("FAIL preset_invalid: got %0d:%0d:%0d expected 13:45:0", hour, minute, second);
    end
    load = 1'b1; load_hour = 7'd8; load_min = 7'd30; inc_hr = 1'b1; cycle();
    load = 1'b0; inc_hr = 1'b0;
    checks++;
    if ({hour, minute, second} !== {7'd8, 7'd30, 7'd0}) begin
      errors++; $display("FAIL preset_priority: got %0d:%0d:%0d expected 8:30:0", hour, minute, second);
    end
  endtask
`endif

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_tick_latency();
    test_rollover();
    test_pause();
    test_collision();
    test_async_reset();
    test_back_to_back();
`ifdef TIME_COUNTER_PRESET_EN
    test_preset();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
